// File: rtl/pbit_pkg.sv
// rtl/pbit_pkg.sv - shared constants, state type and helpers for the p-bit datapath
//
// Purpose: definitions shared by the synapse accumulator and the p-bit tanh stage.
//   Z_WIDTH/Z_MAX/Z_MIN : format of the signed bias z fed to the tanh lookup
//   mac_state_t         : synapse_mac control states
//   clog2_min1          : ceil(log2(n)) with a minimum result of 1, for counter widths
package pbit_pkg;

  localparam int Z_WIDTH = 7;
  localparam int Z_MAX   = 63;
  localparam int Z_MIN   = -64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CLAMP = 2'd2
  } mac_state_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/z_sat_clamp.sv
// rtl/z_sat_clamp.sv - arithmetic shift and saturation of a wide sum into the z format
//
// Purpose: combinational reduction of a signed ACC_WIDTH sum to the signed Z_WIDTH
// bias. The sum is arithmetic-shifted right by SCALE_SHIFT, then clamped to
// Z_MIN..Z_MAX.
// Ports:
//   acc : in  ACC_WIDTH  signed sum
//   z   : out Z_WIDTH    signed clamped result
//   sat : out 1          high when clamping changed the value
module z_sat_clamp
  import pbit_pkg::*;
#(
  parameter int ACC_WIDTH   = 16,
  parameter int SCALE_SHIFT = 0
) (
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [Z_WIDTH-1:0]   z,
  output logic                 sat
);

  localparam logic signed [ACC_WIDTH-1:0] HI = ACC_WIDTH'(Z_MAX);
  localparam logic signed [ACC_WIDTH-1:0] LO = ACC_WIDTH'(Z_MIN);

  logic signed [ACC_WIDTH-1:0] s;

  assign s = $signed(acc) >>> SCALE_SHIFT;

  always_comb begin
    z   = s[Z_WIDTH-1:0];
    sat = 1'b0;
    if (s > HI) begin
      z   = Z_WIDTH'(Z_MAX);
      sat = 1'b1;
    end else if (s < LO) begin
      z   = Z_WIDTH'(Z_MIN);
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/synapse_mac.sv
// rtl/synapse_mac.sv - serial local-field accumulator producing the p-bit bias z
//
// Purpose: computes I = h + sum_j (m_j ? J_j : -J_j), one neighbour per cycle,
// then shifts and clamps I into the 7-bit signed z for the p-bit tanh stage.
// Ports:
//   CLK     : in  1                 clock, rising edge
//   RST     : in  1                 synchronous active-low reset
//   start   : in  1                 request an update (sampled only in IDLE)
//   m_in    : in  N_NEIGH           neighbour states, 1 = +1, 0 = -1
//   weights : in  N_NEIGH*W_WIDTH   flattened signed couplings J_j
//   h_bias  : in  H_WIDTH           signed self-bias
//   busy    : out 1                 update in progress
//   done    : out 1                 one-cycle pulse when z_out/sat update
//   z_out   : out 7                 signed clamped bias, held between updates
//   sat     : out 1                 clamping occurred on the last update
module synapse_mac
  import pbit_pkg::*;
#(
  parameter int N_NEIGH     = 8,
  parameter int W_WIDTH     = 8,
  parameter int H_WIDTH     = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int SCALE_SHIFT = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start,
  input  logic [N_NEIGH-1:0]         m_in,
  input  logic [N_NEIGH*W_WIDTH-1:0] weights,
  input  logic [H_WIDTH-1:0]         h_bias,
  output logic                       busy,
  output logic                       done,
  output logic [Z_WIDTH-1:0]         z_out,
  output logic                       sat
);

  localparam int IDX_W = clog2_min1(N_NEIGH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEIGH - 1);

  mac_state_t state, state_next;

  logic [N_NEIGH-1:0]         m_snap;
  logic [N_NEIGH*W_WIDTH-1:0] w_snap;
  logic [ACC_WIDTH-1:0]       acc;
  logic [IDX_W-1:0]           idx;

  logic [W_WIDTH-1:0]   j_sel;
  logic [ACC_WIDTH-1:0] j_ext;
  logic [ACC_WIDTH-1:0] term;
  logic [Z_WIDTH-1:0]   clamp_z;
  logic                 clamp_sat;

  // Negation happens after sign extension so that the most negative weight
  // flips to its positive magnitude without wrapping.
  assign j_sel = w_snap[idx*W_WIDTH +: W_WIDTH];
  assign j_ext = ACC_WIDTH'($signed(j_sel));
  assign term  = m_snap[idx] ? j_ext : (~j_ext + 1'b1);

  z_sat_clamp #(
    .ACC_WIDTH  (ACC_WIDTH),
    .SCALE_SHIFT(SCALE_SHIFT)
  ) u_clamp (
    .acc(acc),
    .z  (clamp_z),
    .sat(clamp_sat)
  );

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (idx == IDX_LAST) state_next = CLAMP;
      CLAMP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      m_snap <= '0;
      w_snap <= '0;
      acc    <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      z_out  <= '0;
      sat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_snap <= m_in;
            w_snap <= weights;
            acc    <= ACC_WIDTH'($signed(h_bias));
            idx    <= '0;
            busy   <= 1'b1;
          end
        end
        ACCUM: begin
          acc <= acc + term;
          // Hold at the last index instead of wrapping.
          if (idx != IDX_LAST) idx <= idx + 1'b1;
        end
        CLAMP: begin
          z_out <= clamp_z;
          sat   <= clamp_sat;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
